multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Main control FSM of the multi-cycle RV32 datapath.
- Decodes the opcode and sequences fetch, decode, execute, memory and writeback for lw, sw, beq and R-type instructions.
- Drives the datapath mux selects, register/PC/IR write enables and memory strobes, and waits on a memory-ready handshake.
- Counts retired instructions and halts sticky on an unsupported opcode.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  inst[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC register write enable.
- ir_write  out  1  instruction register load.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = regA, 10 = oldPC.
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = constant 4, 10 = sign-extended immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALUOut.
- illegal  out  1  sticky unsupported-opcode flag.
- retired_cnt  out  CNT_W  count of retired instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset state: state = IDLE, all control outputs 0, illegal = 0, retired_cnt = 0. Reset asserted mid-instruction aborts it immediately, with no partial strobes after assertion.
- Output style: Moore decode from state. Every output not listed for a state is 0 in that state.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, HALT=10. Encodings 11-15 go to IDLE.
- IDLE: -> FETCH unconditionally, one cycle after reset release.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; PC and IR do not change during wait cycles.
  - -> DECODE on mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=10, alu_src_b=10, alu_op=00. This computes the branch target oldPC+imm into ALUOut. The immediate already includes bit0=0, so no shift is applied.
  - Next state by opcode: 3 -> MEM_ADDR, 35 -> MEM_ADDR, 51 -> R_EXEC, 99 -> BRANCH, any other -> HALT with illegal set.
- MEM_ADDR:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00.
  - -> MEM_RD if opcode=3, else MEM_WR.
- MEM_RD: iord=1, mem_read=1; hold while mem_ready=0; -> MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1; -> FETCH.
- MEM_WR: iord=1, mem_write=1; hold while mem_ready=0; -> FETCH on mem_ready. Memory commits only in the cycle where mem_write=1 and mem_ready=1.
- R_EXEC: alu_src_a=01, alu_src_b=00, alu_op=10; -> R_WB.
- R_WB: reg_write=1, mem_to_reg=0; -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero; -> FETCH.
- HALT: all control outputs 0; illegal=1; remains in HALT until reset.
- Latency, excluding wait states: lw 5 cycles, sw 4, R-type 4, beq 3.
- Retirement: retired_cnt increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB or BRANCH. It wraps modulo 2^CNT_W without saturating.
- Illegal opcode: never counts as retired.
- Opcode sampling: opcode is sampled from the IR, which is stable after FETCH. opcode changes while in FETCH have no effect.

Decomposition:
- Package ctrl_pkg:
  - state enum and encodings;
  - opcode constants OP_LW=3, OP_SW=35, OP_BEQ=99, OP_R=51;
  - alu_op codes;
  - ALU A/B and pc_source select codes.
- Sub-module ctrl_out_dec: purely combinational state-to-outputs decoder, which keeps the FSM next-state logic separate.

Test Plan:
- Reset release, then lw (opcode 3) with mem_ready=1 -> states 0,1,2,3,4,5,1; reg_write=mem_to_reg=1 only in MEM_WB; retired_cnt=1.
- sw with mem_ready low for 3 cycles in MEM_WR -> mem_write=1 held for 4 cycles; single commit on the mem_ready cycle; then FETCH; retired_cnt +1.
- beq with zero=1 -> pc_en=1 and pc_source=01 in BRANCH. Same with zero=0 -> pc_en=0. Both cases return to FETCH in cycle 3.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_en=0, state holds at 1, then ir_write=pc_en=1 on the ready cycle.
- opcode 7'h13 in DECODE -> HALT, illegal=1, all strobes 0 for 10+ cycles, retired_cnt unchanged; reset clears illegal to 0.
- Reset asserted mid-MEM_RD -> outputs 0 without waiting for a clock edge; state 0; retired_cnt preset to 2^CNT_W-1 wraps to 0 after the next R-type.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control FSM:
// state encodings, opcode constants and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_BEQ = 7'd99;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_out_dec.sv
// Moore state-to-control decoder; only FETCH and BRANCH look at a live input
// (mem_ready and zero respectively) to qualify their write enables.
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  state_t    state,
  input  logic      zero,
  input  logic      mem_ready,
  output ctrl_out_t ctrl
);

  // Decode control strobes and selects from the current state
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // PC and IR only move on the cycle the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_HALT: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 datapath (lw, sw, beq, R-type),
// with a retired-instruction counter and a sticky halt on unsupported opcodes.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_dbg
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             retire_s;
  logic [CNT_W-1:0] cnt_r;
  ctrl_out_t        ctrl_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection and retirement detection
  always_comb begin
    state_nxt_s = S_IDLE;
    retire_s    = 1'b0;
    case (state_r)
      S_IDLE:     state_nxt_s = S_FETCH;
      S_FETCH:    state_nxt_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = S_MEM_ADDR;
          OP_R:         state_nxt_s = S_R_EXEC;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          default:      state_nxt_s = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_nxt_s = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt_s = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: begin
        state_nxt_s = S_FETCH;
        retire_s    = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
          retire_s    = 1'b1;
        end else begin
          state_nxt_s = S_MEM_WR;
        end
      end
      S_R_EXEC:   state_nxt_s = S_R_WB;
      S_R_WB, S_BRANCH: begin
        state_nxt_s = S_FETCH;
        retire_s    = 1'b1;
      end
      S_HALT:     state_nxt_s = S_HALT;
      default:    state_nxt_s = S_IDLE;
    endcase
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (retire_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  ctrl_out_dec u_dec (
    .state     (state_r),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  assign pc_en       = ctrl_s.pc_en;
  assign ir_write    = ctrl_s.ir_write;
  assign iord        = ctrl_s.iord;
  assign mem_read    = ctrl_s.mem_read;
  assign mem_write   = ctrl_s.mem_write;
  assign reg_write   = ctrl_s.reg_write;
  assign mem_to_reg  = ctrl_s.mem_to_reg;
  assign alu_src_a   = ctrl_s.alu_src_a;
  assign alu_src_b   = ctrl_s.alu_src_b;
  assign alu_op      = ctrl_s.alu_op;
  assign pc_source   = ctrl_s.pc_source;
  assign illegal     = ctrl_s.illegal;
  assign retired_cnt = cnt_r;
  assign state_dbg   = state_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Table-driven bench for multi_cycle_ctrl plus hand sequences for async reset
// mid-access and the store commit count. A 3-bit counter makes the wrap reachable.
module tb_multi_cycle_ctrl;

  localparam int CW = 3;

  // Expected output words: {pc_en, ir_write, iord, mem_read, mem_write, reg_write,
  // mem_to_reg, alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal}
  localparam logic [15:0] O_IDLE  = 16'h0000;
  localparam logic [15:0] O_FTW   = 16'h1020;
  localparam logic [15:0] O_FTR   = 16'hD020;
  localparam logic [15:0] O_DEC   = 16'h0140;
  localparam logic [15:0] O_MADDR = 16'h00C0;
  localparam logic [15:0] O_MRD   = 16'h3000;
  localparam logic [15:0] O_MWB   = 16'h0600;
  localparam logic [15:0] O_MWR   = 16'h2800;
  localparam logic [15:0] O_REX   = 16'h0090;
  localparam logic [15:0] O_RWB   = 16'h0400;
  localparam logic [15:0] O_BR0   = 16'h008A;
  localparam logic [15:0] O_BR1   = 16'h808A;
  localparam logic [15:0] O_HALT  = 16'h0001;

  typedef struct {
    logic          rst;
    logic [6:0]    op;
    logic          z;
    logic          rdy;
    logic [3:0]    st;
    logic [15:0]   out;
    logic [CW-1:0] cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, pc_source;
  logic          illegal;
  logic [CW-1:0] retired_cnt;
  logic [3:0]    state_dbg;
  logic [15:0]   act_out;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   commits = 0;

  multi_cycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .retired_cnt(retired_cnt),
    .state_dbg(state_dbg)
  );

  assign act_out = {pc_en, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  always #5 clk = ~clk;

  // Count store commits: mem_write and mem_ready together at a clock edge
  always @(posedge clk) begin
    if (!reset && mem_write && mem_ready) commits <= commits + 1;
  end

  task automatic add(input logic rst, input logic [6:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] out, input int cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy;
    v.st = st; v.out = out; v.cnt = CW'(cnt);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [6:0] op, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // reset, then lw with memory always ready: states 0,1,2,3,4,5,1
    add(1, 7'd3,  0, 1, 4'd0, O_IDLE,  0);
    add(0, 7'd3,  0, 1, 4'd0, O_IDLE,  0);
    add(0, 7'd3,  0, 1, 4'd1, O_FTR,   0);
    add(0, 7'd3,  0, 1, 4'd2, O_DEC,   0);
    add(0, 7'd3,  0, 1, 4'd3, O_MADDR, 0);
    add(0, 7'd3,  0, 1, 4'd4, O_MRD,   0);
    add(0, 7'd3,  0, 1, 4'd5, O_MWB,   0);
    // fetch waits two cycles, opcode wiggles during the wait
    add(0, 7'd99, 0, 0, 4'd1, O_FTW,   1);
    add(0, 7'd51, 0, 0, 4'd1, O_FTW,   1);
    add(0, 7'd35, 0, 1, 4'd1, O_FTR,   1);
    // sw with three wait cycles in MEM_WR
    add(0, 7'd35, 0, 0, 4'd2, O_DEC,   1);
    add(0, 7'd35, 0, 0, 4'd3, O_MADDR, 1);
    add(0, 7'd35, 0, 0, 4'd6, O_MWR,   1);
    add(0, 7'd35, 0, 0, 4'd6, O_MWR,   1);
    add(0, 7'd35, 0, 0, 4'd6, O_MWR,   1);
    add(0, 7'd35, 0, 1, 4'd6, O_MWR,   1);
    // beq taken then not taken
    add(0, 7'd99, 1, 1, 4'd1, O_FTR,   2);
    add(0, 7'd99, 1, 0, 4'd2, O_DEC,   2);
    add(0, 7'd99, 1, 0, 4'd9, O_BR1,   2);
    add(0, 7'd99, 0, 1, 4'd1, O_FTR,   3);
    add(0, 7'd99, 0, 0, 4'd2, O_DEC,   3);
    add(0, 7'd99, 0, 0, 4'd9, O_BR0,   3);
    // R-type
    add(0, 7'd51, 0, 1, 4'd1, O_FTR,   4);
    add(0, 7'd51, 0, 0, 4'd2, O_DEC,   4);
    add(0, 7'd51, 0, 0, 4'd7, O_REX,   4);
    add(0, 7'd51, 0, 0, 4'd8, O_RWB,   4);
    // unsupported opcode 0x13 halts and stays halted whatever the inputs do
    add(0, 7'h13, 0, 1, 4'd1, O_FTR,   5);
    add(0, 7'h13, 0, 0, 4'd2, O_DEC,   5);
    for (int i = 0; i < 12; i++) begin
      add(0, (i % 3 == 0) ? 7'd3 : 7'h13, i[0], ~i[0], 4'd10, O_HALT, 5);
    end
    add(1, 7'h13, 0, 1, 4'd0, O_IDLE,  0);
    // lw stalled in MEM_RD, then reset
    add(0, 7'd3,  0, 1, 4'd0, O_IDLE,  0);
    add(0, 7'd3,  0, 1, 4'd1, O_FTR,   0);
    add(0, 7'd3,  0, 0, 4'd2, O_DEC,   0);
    add(0, 7'd3,  0, 0, 4'd3, O_MADDR, 0);
    add(0, 7'd3,  0, 0, 4'd4, O_MRD,   0);
    add(1, 7'd3,  0, 1, 4'd0, O_IDLE,  0);
    add(0, 7'd51, 0, 1, 4'd0, O_IDLE,  0);
    // eight R-types take the 3-bit counter through 7 and back to 0
    for (int k = 0; k < 8; k++) begin
      add(0, 7'd51, 0, 1, 4'd1, O_FTR, k);
      add(0, 7'd51, 0, 0, 4'd2, O_DEC, k);
      add(0, 7'd51, 0, 0, 4'd7, O_REX, k);
      add(0, 7'd51, 0, 0, 4'd8, O_RWB, k);
    end
    add(0, 7'd51, 0, 0, 4'd1, O_FTW,   0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      n_vec++;
      if ({state_dbg, act_out, retired_cnt} !== {vecs[i].st, vecs[i].out, vecs[i].cnt}) begin
        n_miss++;
        $display("FAIL row%0d: got st=%0d out=%h cnt=%0d, expected st=%0d out=%h cnt=%0d",
                 i, state_dbg, act_out, retired_cnt, vecs[i].st, vecs[i].out, vecs[i].cnt);
      end
    end

    // one R-type after the wrap, then lw into MEM_RD and reset between edges
    step(7'd51, 0, 1);
    step(7'd51, 0, 0);
    step(7'd51, 0, 0);
    step(7'd51, 0, 0);
    step(7'd3, 0, 1);
    chk("cnt_after_wrap", 32'(retired_cnt), 32'd1);
    step(7'd3, 0, 0);
    step(7'd3, 0, 0);
    step(7'd3, 0, 0);
    chk("mrd_state", 32'(state_dbg), 32'd4);
    chk("mrd_out", 32'(act_out), 32'(O_MRD));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_out", 32'(act_out), 32'd0);
    chk("async_rst_cnt", 32'(retired_cnt), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_out", 32'(act_out), 32'd0);
    chk("sw_commits", 32'(commits), 32'd1);

    @(negedge clk);
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
